// File: rtl/sc_ctrl_pkt_gen.sv
// Scrambler control-packet transmitter: serialises host requests into 7-word
// 16-bit packets with a fixed idle gap, holding one request in flight and one pending.
module sc_ctrl_pkt_gen #(
   parameter int         GAP_CYCLES = 4,
   parameter logic [7:0] HDR_TAG    = 8'hA5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cfg_req,
   output logic        cfg_ready,
   input  logic [7:0]  cfg_chan,
   input  logic        cfg_ena,
   input  logic        cfg_parity,
   input  logic [7:0]  cfg_clr_byte,
   input  logic [63:0] cfg_key,
   output logic [15:0] sc_ctrl_pkt_d,
   output logic        sc_ctrl_pkt_dval,
   output logic        sc_ctrl_pkt_eof,
   output logic        pkt_busy,
   output logic [15:0] pkt_sent_cnt
);

   typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

   typedef struct packed {
      logic [7:0]  chan;
      logic        ena;
      logic        parity;
      logic [7:0]  clr_byte;
      logic [63:0] key;
   } cfg_t;

   state_t      state, state_nxt;
   logic [2:0]  word_cnt, word_cnt_nxt;
   logic [7:0]  gap_cnt, gap_cnt_nxt;
   cfg_t        cfg_in, shadow, pend;
   logic        pend_vld;
   logic        accept, load_cfg, load_pend, pend_wr, sent_inc;
   logic        dval_nxt, eof_nxt;
   logic [15:0] d_nxt, csum;

   function automatic logic [15:0] body_word(input cfg_t c, input logic [2:0] idx);
      case (idx)
         3'd0:    body_word = {HDR_TAG, c.chan};
         3'd1:    body_word = {c.ena, c.parity, 6'b0, c.clr_byte};
         3'd2:    body_word = c.key[63:48];
         3'd3:    body_word = c.key[47:32];
         3'd4:    body_word = c.key[31:16];
         3'd5:    body_word = c.key[15:0];
         default: body_word = 16'h0000;
      endcase
   endfunction

   function automatic logic [15:0] checksum(input cfg_t c);
      logic [15:0] acc;
      acc = 16'h0000;
      for (int i = 0; i < 6; i++) acc = acc ^ body_word(c, 3'(i));
      return acc;
   endfunction

   assign cfg_in    = '{chan: cfg_chan, ena: cfg_ena, parity: cfg_parity,
                        clr_byte: cfg_clr_byte, key: cfg_key};
   assign csum      = checksum(shadow);
   assign accept    = cfg_req & ~pend_vld;
   // A request either goes straight to the shadow (line free) or waits in pending.
   assign pend_wr   = accept & ~load_cfg;
   assign cfg_ready = ~pend_vld;
   assign pkt_busy  = (state != IDLE) | pend_vld;

   always_comb begin
      state_nxt    = state;
      word_cnt_nxt = word_cnt;
      gap_cnt_nxt  = gap_cnt;
      load_cfg     = 1'b0;
      load_pend    = 1'b0;
      sent_inc     = 1'b0;
      dval_nxt     = 1'b0;
      eof_nxt      = 1'b0;
      d_nxt        = 16'h0000;
      case (state)
         IDLE: begin
            if (accept) begin
               load_cfg     = 1'b1;
               word_cnt_nxt = 3'd0;
               state_nxt    = SEND;
            end
         end
         SEND: begin
            dval_nxt = 1'b1;
            d_nxt    = (word_cnt == 3'd6) ? csum : body_word(shadow, word_cnt);
            if (word_cnt == 3'd6) begin
               eof_nxt     = 1'b1;
               sent_inc    = 1'b1;
               gap_cnt_nxt = 8'd0;
               state_nxt   = GAP;
            end else begin
               word_cnt_nxt = word_cnt + 3'd1;
            end
         end
         GAP: begin
            if (gap_cnt == 8'(GAP_CYCLES - 1)) begin
               word_cnt_nxt = 3'd0;
               if (pend_vld) begin
                  load_pend = 1'b1;
                  state_nxt = SEND;
               end else if (accept) begin
                  load_cfg  = 1'b1;
                  state_nxt = SEND;
               end else begin
                  state_nxt = IDLE;
               end
            end else begin
               gap_cnt_nxt = gap_cnt + 8'd1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state            <= IDLE;
         word_cnt         <= 3'd0;
         gap_cnt          <= 8'd0;
         pend_vld         <= 1'b0;
         sc_ctrl_pkt_d    <= 16'h0000;
         sc_ctrl_pkt_dval <= 1'b0;
         sc_ctrl_pkt_eof  <= 1'b0;
         pkt_sent_cnt     <= 16'h0000;
      end else begin
         state            <= state_nxt;
         word_cnt         <= word_cnt_nxt;
         gap_cnt          <= gap_cnt_nxt;
         sc_ctrl_pkt_d    <= d_nxt;
         sc_ctrl_pkt_dval <= dval_nxt;
         sc_ctrl_pkt_eof  <= eof_nxt;
         if (sent_inc) pkt_sent_cnt <= pkt_sent_cnt + 16'd1;
         if (load_pend)    pend_vld <= 1'b0;
         else if (pend_wr) pend_vld <= 1'b1;
      end
   end

   // Packet contents carry no reset; they are qualified by state and pend_vld.
   always_ff @(posedge clk) begin
      if (load_cfg)       shadow <= cfg_in;
      else if (load_pend) shadow <= pend;
      if (pend_wr) pend <= cfg_in;
   end

endmodule
